// File: rtl/tpu_matmul_seq.sv
// Job sequencer for the tpuv1 8x8 systolic matrix unit: streams A and B rows in,
// issues the systolic steps, then returns C as half-row beats.
module tpu_matmul_seq #(
    parameter int DIM         = 8,
    parameter int DATA_W      = 32,
    parameter int STEP_CYCLES = 22
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DATA_W-1:0] in_high,
    input  logic [4*DATA_W-1:0] in_low,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DATA_W-1:0] out_data,
    output logic [2:0]          out_row,
    output logic                out_hl,
    output logic                out_last,
    output logic [2:0]          tpu_opcode,
    output logic [3:0]          tpu_idx,
    output logic                tpu_hl,
    output logic [4*DATA_W-1:0] tpu_v_high,
    output logic [4*DATA_W-1:0] tpu_v_low,
    input  logic [4*DATA_W-1:0] tpu_data_out,
    output logic [2:0]          dbg_state
);

    localparam int ROW_W  = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_WRITE_A = 3'd1;
    localparam logic [2:0] OP_WRITE_B = 3'd2;
    localparam logic [2:0] OP_READ_C  = 3'd5;
    localparam logic [2:0] OP_STEP    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_STEP   = 3'd3,
        S_RD_REQ = 3'd4,
        S_RD_CAP = 3'd5,
        S_RD_OUT = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t              state;
    logic [ROW_W-1:0]    row;
    logic                half;
    logic [STEP_W-1:0]   step_cnt;

    // Both streams use the same rule: a beat transfers on a rising edge where
    // valid and ready are both high; valid/data must hold until that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            row      <= '0;
            half     <= 1'b0;
            step_cnt <= '0;
            out_data <= '0;
            out_row  <= '0;
            out_hl   <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            state    <= S_IDLE;
            row      <= '0;
            half     <= 1'b0;
            step_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD_A;
                        row   <= '0;
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (in_valid) begin
                        if (row == ROW_W'(DIM - 1)) begin
                            row      <= '0;
                            step_cnt <= '0;
                            state    <= (state == S_LOAD_A) ? S_LOAD_B : S_STEP;
                        end else begin
                            row <= row + ROW_W'(1);
                        end
                    end
                end
                S_STEP: begin
                    if (step_cnt == STEP_W'(STEP_CYCLES - 1)) begin
                        step_cnt <= '0;
                        row      <= '0;
                        half     <= 1'b1;
                        state    <= S_RD_REQ;
                    end else begin
                        step_cnt <= step_cnt + STEP_W'(1);
                    end
                end
                S_RD_REQ: state <= S_RD_CAP;
                S_RD_CAP: begin
                    // tpuv1 read data is registered: it is valid now, one cycle after readC.
                    out_data <= tpu_data_out;
                    out_row  <= 3'(row);
                    out_hl   <= half;
                    state    <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    if (out_ready) begin
                        if (half) begin
                            half  <= 1'b0;
                            state <= S_RD_REQ;
                        end else if (row == ROW_W'(DIM - 1)) begin
                            row   <= '0;
                            state <= S_DONE;
                        end else begin
                            half  <= 1'b1;
                            row   <= row + ROW_W'(1);
                            state <= S_RD_REQ;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        in_ready   = (state == S_LOAD_A) || (state == S_LOAD_B);
        out_valid  = (state == S_RD_OUT);
        out_last   = out_valid && (row == ROW_W'(DIM - 1)) && !half;
        tpu_opcode = OP_NOP;
        tpu_idx    = '0;
        tpu_hl     = 1'b0;
        tpu_v_high = '0;
        tpu_v_low  = '0;
        case (state)
            S_LOAD_A, S_LOAD_B: begin
                tpu_idx    = 4'(row);
                tpu_v_high = in_high;
                tpu_v_low  = in_low;
                // A stalled input cycle must reach tpuv1 as a nop, never a repeat write.
                if (in_valid) tpu_opcode = (state == S_LOAD_A) ? OP_WRITE_A : OP_WRITE_B;
            end
            S_STEP: tpu_opcode = OP_STEP;
            S_RD_REQ, S_RD_CAP: begin
                tpu_opcode = OP_READ_C;
                tpu_idx    = 4'(row);
                tpu_hl     = half;
            end
            default: ;
        endcase
        dbg_state = state;
    end

endmodule
